// File: rtl/obb_sat_check.sv
// Oriented-bounding-box overlap test using the separating axis theorem.
// All arithmetic runs through one shared signed multiplier and two 32-bit
// accumulators. The relative rotation (c, s) is computed first, then the
// four candidate axes are tested in order until one separates the boxes.
module obb_sat_check #(
    parameter int unsigned CW = 10
) (
    input  logic                 Clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic signed [CW-1:0] a_cx,
    input  logic signed [CW-1:0] a_cy,
    input  logic signed [CW-1:0] b_cx,
    input  logic signed [CW-1:0] b_cy,
    input  logic signed [7:0]    a_ux,
    input  logic signed [7:0]    a_uy,
    input  logic signed [7:0]    b_ux,
    input  logic signed [7:0]    b_uy,
    input  logic signed [7:0]    a_hw,
    input  logic signed [7:0]    a_hh,
    input  logic signed [7:0]    b_hw,
    input  logic signed [7:0]    b_hh,
    output logic                 busy,
    output logic                 done,
    output logic                 hit,
    output logic [1:0]           sep_axis
);

    localparam int unsigned AW  = 12;  // multiplier operand A width
    localparam int unsigned BW  = 18;  // multiplier operand B width
    localparam int unsigned PW  = AW + BW;
    localparam int unsigned ACW = 32;  // accumulator width
    localparam int unsigned TW  = 17;  // Q2.12 rotation term width
    localparam int unsigned EW  = 7;   // clamped extent width
    localparam int unsigned DW  = CW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROT,
        S_AX,
        S_DONE
    } state_t;

    state_t state;
    logic [2:0] cnt;
    logic [1:0] axis;

    logic signed [DW-1:0]  dx;
    logic signed [DW-1:0]  dy;
    logic signed [7:0]     ua_x;
    logic signed [7:0]     ua_y;
    logic signed [7:0]     ub_x;
    logic signed [7:0]     ub_y;
    logic [EW-1:0]         hw_a;
    logic [EW-1:0]         hh_a;
    logic [EW-1:0]         hw_b;
    logic [EW-1:0]         hh_b;
    logic signed [TW-1:0]  c_r;
    logic signed [TW-1:0]  s_r;
    logic signed [ACW-1:0] acc_d;
    logic signed [ACW-1:0] acc_r;

    logic signed [AW-1:0]  mul_a;
    logic signed [BW-1:0]  mul_b;
    logic signed [PW-1:0]  prod;
    logic signed [ACW-1:0] prod_ext;
    logic signed [BW-1:0]  c_abs;
    logic signed [BW-1:0]  s_abs;
    logic signed [7:0]     u0_sel;
    logic signed [7:0]     u1_sel;
    logic [EW-1:0]         prim;
    logic [EW-1:0]         oth_hw;
    logic [EW-1:0]         oth_hh;
    logic signed [ACW-1:0] prim_sh;
    logic signed [ACW-1:0] abs_d;
    logic signed [ACW-1:0] dn;
    logic                  separated;

    // Negative extents are treated as empty.
    function automatic logic [EW-1:0] clamp_ext(input logic signed [7:0] e);
        return e[7] ? EW'(0) : e[EW-1:0];
    endfunction

    // Operand selection for the shared multiplier and the axis compare.
    always_comb begin
        mul_a   = '0;
        mul_b   = '0;
        c_abs   = c_r[TW-1] ? -BW'(c_r) : BW'(c_r);
        s_abs   = s_r[TW-1] ? -BW'(s_r) : BW'(s_r);
        oth_hw  = axis[1] ? hw_a : hw_b;
        oth_hh  = axis[1] ? hh_a : hh_b;
        u0_sel  = ua_x;
        u1_sel  = ua_y;
        prim    = hw_a;
        case (axis)
            2'd0: begin u0_sel = ua_x; u1_sel = ua_y; prim = hw_a; end
            2'd1: begin u0_sel = ua_y; u1_sel = ua_x; prim = hh_a; end
            2'd2: begin u0_sel = ub_x; u1_sel = ub_y; prim = hw_b; end
            default: begin u0_sel = ub_y; u1_sel = ub_x; prim = hh_b; end
        endcase
        case (state)
            S_ROT: begin
                case (cnt)
                    3'd0: begin mul_a = AW'(ua_x); mul_b = BW'(ub_x); end
                    3'd1: begin mul_a = AW'(ua_y); mul_b = BW'(ub_y); end
                    3'd2: begin mul_a = AW'(ua_x); mul_b = BW'(ub_y); end
                    3'd3: begin mul_a = AW'(ua_y); mul_b = BW'(ub_x); end
                    default: ;
                endcase
            end
            S_AX: begin
                case (cnt)
                    3'd0: begin mul_a = AW'(dx); mul_b = BW'(u0_sel); end
                    3'd1: begin mul_a = AW'(dy); mul_b = BW'(u1_sel); end
                    3'd2: begin
                        mul_a = $signed(AW'(oth_hw));
                        mul_b = axis[0] ? s_abs : c_abs;
                    end
                    3'd3: begin
                        mul_a = $signed(AW'(oth_hh));
                        mul_b = axis[0] ? c_abs : s_abs;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        prod      = PW'(mul_a) * PW'(mul_b);
        prod_ext  = ACW'(prod);
        prim_sh   = $signed(ACW'(prim)) <<< 12;
        abs_d     = acc_d[ACW-1] ? -acc_d : acc_d;
        dn        = abs_d <<< 6;
        separated = dn > acc_r;
    end

    // Control FSM, input latching, MAC accumulation and result registers.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            axis     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hit      <= 1'b0;
            sep_axis <= '0;
            dx       <= '0;
            dy       <= '0;
            ua_x     <= '0;
            ua_y     <= '0;
            ub_x     <= '0;
            ub_y     <= '0;
            hw_a     <= '0;
            hh_a     <= '0;
            hw_b     <= '0;
            hh_b     <= '0;
            c_r      <= '0;
            s_r      <= '0;
            acc_d    <= '0;
            acc_r    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    // A start seen during the done cycle is not accepted.
                    if (start && !done) begin
                        dx    <= DW'(b_cx) - DW'(a_cx);
                        dy    <= DW'(b_cy) - DW'(a_cy);
                        ua_x  <= a_ux;
                        ua_y  <= a_uy;
                        ub_x  <= b_ux;
                        ub_y  <= b_uy;
                        hw_a  <= clamp_ext(a_hw);
                        hh_a  <= clamp_ext(a_hh);
                        hw_b  <= clamp_ext(b_hw);
                        hh_b  <= clamp_ext(b_hh);
                        busy  <= 1'b1;
                        cnt   <= '0;
                        state <= S_ROT;
                    end
                end
                S_ROT: begin
                    case (cnt)
                        3'd0: acc_d <= prod_ext;
                        3'd1: c_r   <= TW'(acc_d + prod_ext);
                        3'd2: acc_d <= prod_ext;
                        default: s_r <= TW'(acc_d - prod_ext);
                    endcase
                    if (cnt == 3'd3) begin
                        cnt   <= '0;
                        axis  <= '0;
                        state <= S_AX;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_AX: begin
                    case (cnt)
                        3'd0: acc_d <= prod_ext;
                        // Secondary axes use v = (-uy, ux); sign is irrelevant under |.|.
                        3'd1: acc_d <= axis[0] ? (acc_d - prod_ext) : (acc_d + prod_ext);
                        3'd2: acc_r <= prim_sh + prod_ext;
                        3'd3: acc_r <= acc_r + prod_ext;
                        default: ;
                    endcase
                    if (cnt == 3'd4) begin
                        cnt <= '0;
                        if (separated) begin
                            hit      <= 1'b0;
                            sep_axis <= axis;
                            state    <= S_DONE;
                        end else if (axis == 2'd3) begin
                            hit      <= 1'b1;
                            sep_axis <= '0;
                            state    <= S_DONE;
                        end else begin
                            axis <= axis + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obb_sat_check.sv
// Scoreboard bench for obb_sat_check: expected results are queued at accept
// and compared (hit, sep_axis, latency) when done pulses.
module tb_obb_sat_check;

    localparam int CW = 10;

    logic                 Clk;
    logic                 reset_n;
    logic                 start;
    logic signed [CW-1:0] a_cx, a_cy, b_cx, b_cy;
    logic signed [7:0]    a_ux, a_uy, b_ux, b_uy;
    logic signed [7:0]    a_hw, a_hh, b_hw, b_hh;
    logic                 busy, done, hit;
    logic [1:0]           sep_axis;

    typedef struct {
        int hit;
        int sep;
        int lat;
        int acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    obb_sat_check #(.CW(CW)) dut (
        .Clk(Clk), .reset_n(reset_n), .start(start),
        .a_cx(a_cx), .a_cy(a_cy), .b_cx(b_cx), .b_cy(b_cy),
        .a_ux(a_ux), .a_uy(a_uy), .b_ux(b_ux), .b_uy(b_uy),
        .a_hw(a_hw), .a_hh(a_hh), .b_hw(b_hw), .b_hh(b_hh),
        .busy(busy), .done(done), .hit(hit), .sep_axis(sep_axis)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Edge counter used to measure latency.
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Reference SAT model on plain integers.
    function automatic exp_t model(input int acx, acy, aux, auy, ahw, ahh,
                                   input int bcx, bcy, bux, buy, bhw, bhh);
        exp_t e;
        int dx, dy, c, s, proj, d, r, prim, ohw, ohh, k1, k2;
        int nx[4];
        int ny[4];
        if (ahw < 0) ahw = 0;
        if (ahh < 0) ahh = 0;
        if (bhw < 0) bhw = 0;
        if (bhh < 0) bhh = 0;
        dx = bcx - acx;
        dy = bcy - acy;
        c  = aux * bux + auy * buy;
        s  = aux * buy - auy * bux;
        nx[0] = aux;  ny[0] = auy;
        nx[1] = -auy; ny[1] = aux;
        nx[2] = bux;  ny[2] = buy;
        nx[3] = -buy; ny[3] = bux;
        e.acc = 0;
        for (int n = 0; n < 4; n++) begin
            proj = dx * nx[n] + dy * ny[n];
            d    = iabs(proj) * 64;
            prim = (n == 0) ? ahw : (n == 1) ? ahh : (n == 2) ? bhw : bhh;
            ohw  = (n < 2) ? bhw : ahw;
            ohh  = (n < 2) ? bhh : ahh;
            k1   = (n % 2 == 0) ? iabs(c) : iabs(s);
            k2   = (n % 2 == 0) ? iabs(s) : iabs(c);
            r    = prim * 4096 + ohw * k1 + ohh * k2;
            if (d > r) begin
                e.hit = 0;
                e.sep = n;
                e.lat = 5 + 5 * (n + 1);
                return e;
            end
        end
        e.hit = 1;
        e.sep = 0;
        e.lat = 25;
        return e;
    endfunction

    // Compare each done pulse against the oldest queued expectation.
    always begin
        @(posedge Clk);
        #1;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("hit", int'(hit), mon_e.hit);
                chk("sep_axis", int'(sep_axis), mon_e.sep);
                chk("latency", cyc - mon_e.acc, mon_e.lat);
            end
        end
    end

    task automatic apply(input int acx, acy, aux, auy, ahw, ahh,
                         input int bcx, bcy, bux, buy, bhw, bhh);
        a_cx = CW'(acx); a_cy = CW'(acy); a_ux = 8'(aux); a_uy = 8'(auy);
        a_hw = 8'(ahw);  a_hh = 8'(ahh);
        b_cx = CW'(bcx); b_cy = CW'(bcy); b_ux = 8'(bux); b_uy = 8'(buy);
        b_hw = 8'(bhw);  b_hh = 8'(bhh);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80; i++) begin
            if (!busy && !done && sb.size() == 0) break;
            @(negedge Clk);
        end
        if (busy || done || sb.size() != 0) begin
            chk("idle_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(negedge Clk);
        end
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // Launch one test; eh < 0 takes the expectation from the model.
    task automatic run_case(input int acx, acy, aux, auy, ahw, ahh,
                            input int bcx, bcy, bux, buy, bhw, bhh,
                            input int eh, es, el);
        exp_t e;
        wait_idle();
        apply(acx, acy, aux, auy, ahw, ahh, bcx, bcy, bux, buy, bhw, bhh);
        if (eh < 0) begin
            e = model(acx, acy, aux, auy, ahw, ahh, bcx, bcy, bux, buy, bhw, bhh);
        end else begin
            e.hit = eh; e.sep = es; e.lat = el;
        end
        start = 1'b1;
        @(negedge Clk);
        e.acc = cyc;
        chk("accept_busy", int'(busy), 1);
        sb.push_back(e);
        start = 1'b0;
    endtask

    initial begin
        exp_t e2;
        reset_n = 1'b0;
        start   = 1'b0;
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_sep", int'(sep_axis), 0);
        @(negedge Clk);
        reset_n = 1'b1;
        @(negedge Clk);

        // Separated on uA, touching, separated on vA.
        run_case(0, 0, 64, 0, 10, 10, 30, 0, 64, 0, 10, 10, 0, 0, 10); drain();
        run_case(0, 0, 64, 0, 10, 10, 20, 0, 64, 0, 10, 10, 1, 0, 25); drain();
        run_case(0, 0, 64, 0, 10, 10, 0, 30, 64, 0, 10, 10, 0, 1, 15); drain();
        // Rotated boxes.
        run_case(0, 0, 64, 0, 20, 5, 22, 0, 0, 64, 20, 5, 1, 0, 25); drain();
        run_case(0, 0, 64, 0, 20, 5, 26, 0, 0, 64, 20, 5, 0, 0, 10); drain();
        // Negative half-width must clamp to zero (coincident boxes touch).
        run_case(0, 0, 64, 0, -1, 10, 0, 0, 64, 0, -1, 10, 1, 0, 25); drain();

        // Start pulses and input changes during a busy test.
        run_case(0, 0, 64, 0, 10, 10, 30, 0, 64, 0, 10, 10, 0, 0, 10);
        @(negedge Clk);
        start = 1'b1;
        apply(0, 0, 64, 0, 10, 10, 20, 0, 64, 0, 10, 10);
        @(negedge Clk);
        start = 1'b0;
        repeat (2) @(negedge Clk);
        start = 1'b1;
        apply(5, 5, 0, 64, 1, 1, 9, 9, 0, 64, 1, 1);
        @(negedge Clk);
        start = 1'b0;
        drain();
        repeat (20) @(negedge Clk);

        // Start held high across done: ignored in the done cycle, taken next edge.
        wait_idle();
        apply(0, 0, 64, 0, 10, 10, 0, 30, 64, 0, 10, 10);
        start = 1'b1;
        @(negedge Clk);
        e2.hit = 0; e2.sep = 1; e2.lat = 15; e2.acc = cyc;
        sb.push_back(e2);
        drain();
        chk("busy_at_done", int'(busy), 0);
        chk("done_pulse", int'(done), 1);
        @(negedge Clk);
        chk("start_ignored_busy", int'(busy), 0);
        chk("done_one_cycle", int'(done), 0);
        @(negedge Clk);
        chk("reaccept_busy", int'(busy), 1);
        e2.acc = cyc;
        sb.push_back(e2);
        start = 1'b0;
        drain();

        // Reset during ROT aborts the test with no done.
        run_case(0, 0, 64, 0, 10, 10, 20, 0, 64, 0, 10, 10, 1, 0, 25); drain();
        run_case(0, 0, 64, 0, 10, 10, 30, 0, 64, 0, 10, 10, 0, 0, 10);
        @(posedge Clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_hit", int'(hit), 0);
        chk("abort_sep", int'(sep_axis), 0);
        sb.delete();
        @(negedge Clk);
        reset_n = 1'b1;
        repeat (30) @(negedge Clk);
        run_case(0, 0, 64, 0, 10, 10, 0, 30, 64, 0, 10, 10, 0, 1, 15); drain();

        // Random boxes against the model.
        for (int i = 0; i < 24; i++) begin
            run_case(int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200,
                     int'($urandom_range(0, 128)) - 64, int'($urandom_range(0, 128)) - 64,
                     int'($urandom_range(0, 63)) - 3, int'($urandom_range(0, 63)) - 3,
                     int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200,
                     int'($urandom_range(0, 128)) - 64, int'($urandom_range(0, 128)) - 64,
                     int'($urandom_range(0, 63)) - 3, int'($urandom_range(0, 63)) - 3,
                     -1, 0, 0);
            drain();
        end

        repeat (5) @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/obb_sat_check.md
OBB_SAT_CHECK -- requirements
Module: obb_sat_check

Interface
REQ-001 Parameter: CW, default 10, bit width of signed integer box-center coordinates.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a test; sampled only in IDLE.
REQ-005 a_cx, a_cy / b_cx, b_cy  input  CW each  signed integer centers of box A / box B.
REQ-006 a_ux, a_uy / b_ux, b_uy  input  8 each  signed Q1.6 unit primary axis (64 = 1.0); secondary axis v = (-uy, ux).
REQ-007 a_hw, a_hh / b_hw, b_hh  input  8 each  signed half-width / half-height in integer pixels.
REQ-008 busy  output  1  high from accept until done.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 hit  output  1  1 = boxes overlap; valid from done, held until next accept.
REQ-011 sep_axis  output  2  first separating axis (0 = uA, 1 = vA, 2 = uB, 3 = vB); 0 when hit = 1.

Function
REQ-012 Accept = start high in IDLE at a rising edge; all 16 box inputs are latched on that edge, and later input changes do not affect the test in progress.
REQ-013 Negative extents are clamped to 0 when latched.
REQ-014 start while busy is ignored, with no queuing.
REQ-015 Datapath: one signed 12x18 multiplier; at most one product per cycle; 32-bit signed accumulators.
REQ-016 States: IDLE -> ROT (4 cycles) -> AX0..AX3 (5 cycles each: 4 MAC + 1 compare) -> DONE (1 cycle) -> IDLE.
REQ-017 ROT computes c = uAx*uBx + uAy*uBy and s = uAx*uBy - uAy*uBx (Q2.12, 17-bit signed).
REQ-018 Each axis n computes dn = |D.n| * 64 with D = B center - A center (CW+1 bits, no overflow); that is two MAC cycles.
REQ-019 Each axis computes the projected extent sum r (Q.12) in two MAC cycles; the primary term is the extent << 12.
REQ-020 Axis uA: r = hwA<<12 + hwB*|c| + hhB*|s|.
REQ-021 Axis vA: r = hhA<<12 + hwB*|s| + hhB*|c|.
REQ-022 Axis uB: r = hwB<<12 + hwA*|c| + hhA*|s|.
REQ-023 Axis vB: r = hhB<<12 + hwA*|s| + hhA*|c|.
REQ-024 Compare cycle: dn > r means separated, so go to DONE with hit = 0 and sep_axis = axis index. dn == r (touching) counts as overlap.
REQ-025 If dn <= r on AX3, go to DONE with hit = 1.
REQ-026 Latency: done is high exactly one cycle, L = 5 + 5k edges after the accepting edge, where k = axes evaluated (1..4); maximum 25.
REQ-027 busy falls in the same cycle done is high. start in the cycle done is high is ignored; it is accepted on the next edge if still high.
REQ-028 hit and sep_axis update only on the edge that enters DONE.

Reset
REQ-029 reset_n low forces IDLE immediately and asynchronously, at any time including mid-test, and sets busy = 0, done = 0, hit = 0, sep_axis = 0.
REQ-030 An aborted test never produces done. The first accept after deassertion starts a fresh test with new latched inputs.

Verification
REQ-031 Reset: reset_n low mid-ROT -> all outputs 0 at once; no done follows.
REQ-032 Separated on axis 0: uA = uB = (64,0), centers (0,0) and (30,0), all extents 10; dn = 122880 > r = 81920 -> done at L = 10, hit = 0, sep_axis = 0.
REQ-033 Touching: same as REQ-032 but B center (20,0); dn = r = 81920 on axis 0 -> all 4 axes pass -> done at L = 25, hit = 1, sep_axis = 0.
REQ-034 Separated on axis 1: same as REQ-032 but B center (0,30) -> done at L = 15, hit = 0, sep_axis = 1.
REQ-035 Rotated: uA = (64,0), uB = (0,64), hwA = hwB = 20, hhA = hhB = 5. D = (22,0) -> hit = 1 at L = 25. D = (26,0) -> dn = 106496 > 102400, so hit = 0, sep_axis = 0, L = 10.
REQ-036 Protocol: pulse start at cycles 2 and 5 of a busy test and change inputs mid-test -> exactly one done, result unchanged. Negative extent -1 behaves as 0.
